// File: rtl/ir_carrier_gen.sv
// IR carrier generator: programmable period/high-time carrier with period-aligned
// mark/space gating, deferred reloads, and edge/period strobes.
module ir_carrier_gen #(
   parameter int unsigned DIV_W          = 16,
   parameter int unsigned DEFAULT_PERIOD = 1389,
   parameter int unsigned DEFAULT_HIGH   = 694
) (
   input  logic             In_Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [DIV_W-1:0] Period_In,
   input  logic [DIV_W-1:0] High_In,
   input  logic             Load,
   input  logic             Mod_In,
   output logic             Out_Clock,
   output logic             Carrier_Raw,
   output logic             Half_Tick,
   output logic             Period_Tick,
   output logic             Load_Pending
);

   localparam logic [DIV_W-1:0] DEF_PERIOD = DIV_W'(DEFAULT_PERIOD);
   localparam logic [DIV_W-1:0] DEF_HIGH   = DIV_W'(DEFAULT_HIGH);

   logic [DIV_W-1:0] count_q, count_d;
   logic [DIV_W-1:0] period_act_q, period_act_d;
   logic [DIV_W-1:0] high_act_q, high_act_d;
   logic [DIV_W-1:0] shadow_period_q, shadow_period_d;
   logic [DIV_W-1:0] shadow_high_q, shadow_high_d;
   logic             load_pending_q, load_pending_d;
   logic             gate_q, gate_d;
   logic             en_q, en_d;
   logic             out_clock_q, out_clock_d;
   logic             carrier_raw_q, carrier_raw_d;
   logic             half_tick_q, half_tick_d;
   logic             period_tick_q, period_tick_d;

   logic [DIV_W-1:0] period_clamp;
   logic [DIV_W-1:0] high_clamp;

   always_comb begin
      period_clamp = (Period_In < DIV_W'(2)) ? DIV_W'(2) : Period_In;
      high_clamp   = (High_In > period_clamp) ? period_clamp : High_In;

      count_d         = count_q;
      period_act_d    = period_act_q;
      high_act_d      = high_act_q;
      shadow_period_d = shadow_period_q;
      shadow_high_d   = shadow_high_q;
      load_pending_d  = load_pending_q;
      gate_d          = gate_q;
      en_d            = Enable;

      if (!Enable) begin
         // Idle: any pending or fresh request applies immediately; a fresh Load wins.
         count_d        = '0;
         gate_d         = 1'b0;
         load_pending_d = 1'b0;
         if (Load) begin
            period_act_d = period_clamp;
            high_act_d   = high_clamp;
         end else if (load_pending_q) begin
            period_act_d = shadow_period_q;
            high_act_d   = shadow_high_q;
         end
      end else if (!en_q) begin
         count_d = '0;
         gate_d  = Mod_In;
         if (Load) begin
            shadow_period_d = period_clamp;
            shadow_high_d   = high_clamp;
            load_pending_d  = 1'b1;
         end
      end else if (count_q == period_act_q - DIV_W'(1)) begin
         count_d        = '0;
         gate_d         = Mod_In;
         load_pending_d = 1'b0;
         if (Load) begin
            period_act_d = period_clamp;
            high_act_d   = high_clamp;
         end else if (load_pending_q) begin
            period_act_d = shadow_period_q;
            high_act_d   = shadow_high_q;
         end
      end else begin
         count_d = count_q + DIV_W'(1);
         if (Load) begin
            shadow_period_d = period_clamp;
            shadow_high_d   = high_clamp;
            load_pending_d  = 1'b1;
         end
      end

      // Outputs are registered from the post-edge count and settings.
      carrier_raw_d = Enable && (count_d < high_act_d);
      out_clock_d   = carrier_raw_d && gate_d;
      period_tick_d = Enable && (count_d == period_act_d - DIV_W'(1));
      half_tick_d   = Enable && (high_act_d != '0) && (high_act_d < period_act_d) &&
                      ((count_d == '0) || (count_d == high_act_d));
   end

   always_ff @(posedge In_Clock) begin
      if (Reset) begin
         count_q         <= '0;
         period_act_q    <= DEF_PERIOD;
         high_act_q      <= DEF_HIGH;
         shadow_period_q <= DEF_PERIOD;
         shadow_high_q   <= DEF_HIGH;
         load_pending_q  <= 1'b0;
         gate_q          <= 1'b0;
         en_q            <= 1'b0;
         out_clock_q     <= 1'b0;
         carrier_raw_q   <= 1'b0;
         half_tick_q     <= 1'b0;
         period_tick_q   <= 1'b0;
      end else begin
         count_q         <= count_d;
         period_act_q    <= period_act_d;
         high_act_q      <= high_act_d;
         shadow_period_q <= shadow_period_d;
         shadow_high_q   <= shadow_high_d;
         load_pending_q  <= load_pending_d;
         gate_q          <= gate_d;
         en_q            <= en_d;
         out_clock_q     <= out_clock_d;
         carrier_raw_q   <= carrier_raw_d;
         half_tick_q     <= half_tick_d;
         period_tick_q   <= period_tick_d;
      end
   end

   assign Out_Clock    = out_clock_q;
   assign Carrier_Raw  = carrier_raw_q;
   assign Half_Tick    = half_tick_q;
   assign Period_Tick  = period_tick_q;
   assign Load_Pending = load_pending_q;

endmodule

// File: tb/tb_ir_carrier_gen.sv
// Randomized + directed bench for ir_carrier_gen, checked every cycle against a
// behavioural model built from phase position within the active period.
module tb_ir_carrier_gen;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Enable = 1'b0;
   logic [15:0] Period_In = '0;
   logic [15:0] High_In = '0;
   logic        Load = 1'b0;
   logic        Mod_In = 1'b0;
   logic        Out_Clock, Carrier_Raw, Half_Tick, Period_Tick, Load_Pending;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ir_carrier_gen #(.DIV_W(16), .DEFAULT_PERIOD(1389), .DEFAULT_HIGH(694)) dut (
      .In_Clock(clk), .Reset(Reset), .Enable(Enable), .Period_In(Period_In),
      .High_In(High_In), .Load(Load), .Mod_In(Mod_In), .Out_Clock(Out_Clock),
      .Carrier_Raw(Carrier_Raw), .Half_Tick(Half_Tick), .Period_Tick(Period_Tick),
      .Load_Pending(Load_Pending));

   // Model: phase = position inside the current period, plus active/requested settings.
   int  m_phase, m_per, m_high, m_req_per, m_req_high;
   bit  m_pend, m_mark, m_running, m_valid;

   always @(posedge clk) begin
      int p, h;
      logic [4:0] exp_v, act_v;
      p = (int'(Period_In) < 2) ? 2 : int'(Period_In);
      h = (int'(High_In) > p) ? p : int'(High_In);
      if (Reset) begin
         m_phase = 0; m_per = 1389; m_high = 694; m_req_per = 1389; m_req_high = 694;
         m_pend = 0; m_mark = 0; m_running = 0; m_valid = 1;
      end else if (!Enable) begin
         if (Load) begin m_per = p; m_high = h; end
         else if (m_pend) begin m_per = m_req_per; m_high = m_req_high; end
         m_pend = 0; m_phase = 0; m_mark = 0; m_running = 0;
      end else begin
         bool_step(p, h);
      end
      exp_v[4] = Enable && !Reset && m_mark && (m_phase < m_high);
      exp_v[3] = Enable && !Reset && (m_phase < m_high);
      exp_v[2] = Enable && !Reset && m_high > 0 && m_high < m_per &&
                 (m_phase == 0 || m_phase == m_high);
      exp_v[1] = Enable && !Reset && (m_phase == m_per - 1);
      exp_v[0] = m_pend;
      #1;
      act_v = {Out_Clock, Carrier_Raw, Half_Tick, Period_Tick, Load_Pending};
      if (m_valid) begin
         n_cmp++;
         if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL cycle_model t=%0t got out/raw/half/tick/pend=%b expected %b",
                     $time, act_v, exp_v);
         end
      end
   end

   task automatic bool_step(input int p, input int h);
      bit at_end;
      at_end = m_running && ((m_phase + 1) % m_per == 0);
      if (!m_running) begin
         m_phase = 0; m_mark = Mod_In; m_running = 1;
         if (Load) begin m_req_per = p; m_req_high = h; m_pend = 1; end
      end else if (at_end) begin
         if (Load) begin m_per = p; m_high = h; end
         else if (m_pend) begin m_per = m_req_per; m_high = m_req_high; end
         m_pend = 0; m_phase = 0; m_mark = Mod_In;
      end else begin
         m_phase = m_phase + 1;
         if (Load) begin m_req_per = p; m_req_high = h; m_pend = 1; end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_tick();
      int n = 0;
      while (!Period_Tick && n < 5000) begin n++; @(negedge clk); end
      if (!Period_Tick) chk("period_tick_timeout", 0, 1);
   endtask

   task automatic run_len(input logic lvl, output int n);
      n = 0;
      while (Out_Clock === lvl && n < 5000) begin n++; @(negedge clk); end
   endtask

   task automatic pulse_load(input int p, input int h);
      Period_In = 16'(p); High_In = 16'(h); Load = 1'b1;
      @(negedge clk);
      Load = 1'b0;
   endtask

   task automatic sample(input int cycles, output int raw, output int half, output int tk);
      raw = 0; half = 0; tk = 0;
      for (int i = 0; i < cycles; i++) begin
         raw += int'(Carrier_Raw); half += int'(Half_Tick); tk += int'(Period_Tick);
         @(negedge clk);
      end
   endtask

   initial begin
      int n, raw, half, tk;
      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({Out_Clock, Carrier_Raw, Half_Tick, Period_Tick}), 0);
      chk("reset_pending", int'(Load_Pending), 0);

      // Defaults: 694 high / 695 low, 1389-cycle period.
      Reset = 1'b0; Enable = 1'b1; Mod_In = 1'b1;
      @(negedge clk);
      chk("first_out", int'(Out_Clock), 1);
      chk("first_raw", int'(Carrier_Raw), 1);
      chk("first_half", int'(Half_Tick), 1);
      run_len(1'b1, n); chk("default_high_len", n, 694);
      run_len(1'b0, n); chk("default_low_len", n, 695);
      wait_tick();
      n = 0;
      do begin @(negedge clk); n++; end while (!Period_Tick && n < 3000);
      chk("default_tick_spacing", n, 1389);

      // Mid-period reload 10/3 deferred to wrap.
      @(negedge clk);
      repeat (100) @(negedge clk);
      pulse_load(10, 3);
      chk("reload_pending", int'(Load_Pending), 1);
      wait_tick();
      chk("pending_at_tick", int'(Load_Pending), 1);
      @(negedge clk);
      chk("pending_cleared", int'(Load_Pending), 0);
      run_len(1'b1, n); chk("reload_high_len", n, 3);
      run_len(1'b0, n); chk("reload_low_len", n, 7);

      // Space takes effect only from the next period start.
      Mod_In = 1'b0;
      wait_tick();
      @(negedge clk);
      chk("space_out", int'(Out_Clock), 0);
      chk("space_raw", int'(Carrier_Raw), 1);
      chk("space_half", int'(Half_Tick), 1);
      Mod_In = 1'b1;

      // Clamp: period 1 -> 2, high 5 -> 2 (constant high).
      pulse_load(1, 5);
      wait_tick(); @(negedge clk);
      sample(10, raw, half, tk);
      chk("clamp_raw", raw, 10); chk("clamp_half", half, 0); chk("clamp_ticks", tk, 5);

      // High 0: constant low.
      pulse_load(6, 0);
      wait_tick(); @(negedge clk);
      sample(12, raw, half, tk);
      chk("zero_raw", raw, 0); chk("zero_half", half, 0); chk("zero_ticks", tk, 2);

      // Double load: only the last one applies.
      wait_tick(); @(negedge clk);
      pulse_load(20, 10);
      pulse_load(8, 4);
      wait_tick(); @(negedge clk);
      run_len(1'b1, n); chk("double_high_len", n, 4);
      run_len(1'b0, n); chk("double_low_len", n, 4);

      // Reset mid-period with a pending load restores defaults.
      pulse_load(2000, 1000);
      wait_tick(); @(negedge clk);
      repeat (500) @(negedge clk);
      pulse_load(30, 5);
      chk("pre_reset_pending", int'(Load_Pending), 1);
      Reset = 1'b1;
      @(negedge clk);
      chk("midreset_outputs", int'({Out_Clock, Carrier_Raw, Half_Tick, Period_Tick}), 0);
      chk("midreset_pending", int'(Load_Pending), 0);
      Reset = 1'b0;
      @(negedge clk);
      run_len(1'b1, n); chk("post_reset_high_len", n, 694);

      // Randomized traffic with small periods, checked by the model.
      pulse_load(12, 5);
      for (int i = 0; i < 6000; i++) begin
         Load      = ($urandom_range(0, 99) < 4);
         Period_In = 16'($urandom_range(0, 40));
         High_In   = 16'($urandom_range(0, 45));
         if ($urandom_range(0, 99) < 6) Mod_In = ~Mod_In;
         if ($urandom_range(0, 99) < 3) Enable = ~Enable;
         Reset = ($urandom_range(0, 999) < 3);
         @(negedge clk);
      end
      Load = 1'b0; Reset = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ir_carrier_gen.md
Name: ir_carrier_gen

Overview:
- Parametrised successor to the fixed 36 kHz IR clock divider.
- Generates an IR carrier from the 50 MHz base clock with runtime-programmable period and high time.
- Carrier changes only at period boundaries (glitch-free). Mark/space gating is aligned to carrier periods, so no runt pulses occur.
- Also emits per-edge and per-period strobes for the IR transmit/receive logic.

Parameters:
- DIV_W, 16, width of the period/high counters and programming ports.
- DEFAULT_PERIOD, 1389, period in base-clock cycles after reset (50 MHz / 36 kHz).
- DEFAULT_HIGH, 694, high-time in base-clock cycles after reset.

Ports:
- In_Clock  in  1  base clock, 50 MHz, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  1 = carrier running; 0 = counter held, outputs low.
- Period_In  in  DIV_W  requested period in cycles, captured on Load.
- High_In  in  DIV_W  requested high-time in cycles, captured on Load.
- Load  in  1  single-cycle request to capture Period_In/High_In.
- Mod_In  in  1  modulation: 1 = mark (carrier emitted), 0 = space.
- Out_Clock  out  1  gated carrier.
- Carrier_Raw  out  1  ungated carrier.
- Half_Tick  out  1  1-cycle pulse at each carrier edge.
- Period_Tick  out  1  1-cycle pulse on the last cycle of each period.
- Load_Pending  out  1  captured values are waiting for a period boundary.

Behaviour:
- Reset (synchronous, highest priority):
  - Count=0, Period_Act=DEFAULT_PERIOD, High_Act=DEFAULT_HIGH.
  - Shadow regs = defaults, Load_Pending=0, Gate=0.
  - All outputs 0.
  - A reset mid-period abandons the period immediately and discards any pending load.
- Clamping, applied at capture:
  - Period < 2 is stored as 2.
  - High > Period is stored as Period (constant high).
  - High = 0 gives constant low.
- Counter:
  - With Enable=1, Count runs 0..Period_Act-1, then wraps to 0.
  - With Enable=0, Count is forced to 0.
- Outputs are registered; they change on the same edge as Count and reflect the new Count value.
- Carrier_Raw = Enable && (Count < High_Act). With the defaults this gives 694 cycles high and 695 cycles low.
- Out_Clock = Carrier_Raw && Gate.
- Gate:
  - Loaded from Mod_In only on the wrap edge (Count == Period_Act-1 -> 0).
  - Gate changes therefore take effect from Count=0 of the next period.
  - When Enable goes from 0 to 1, Gate is loaded from Mod_In on that same edge.
- Period_Tick is 1 while Count == Period_Act-1 and Enable=1.
- Half_Tick is 1 in the cycle where Count==0 or Count==High_Act, and only when Enable=1 and 0 < High_Act < Period_Act. This gives two pulses per period; it is not gated by Mod_In.
- Load with Enable=1:
  - Values are captured into the shadow regs and Load_Pending=1.
  - On the next wrap edge: Period_Act/High_Act take the shadow values, Count=0, Load_Pending=0.
  - Load coincident with the wrap edge: the new values apply at that wrap.
  - Load while already pending: the newest values overwrite the shadow regs; only the last one is applied.
- Load with Enable=0: values apply on the next edge; Load_Pending never asserts.
- Enable falling mid-period:
  - Count goes to 0 and Gate to 0 on the next edge; all outputs go low.
  - A pending load is applied on that edge.
- Enable rising: first enabled cycle has Count=0, so Carrier_Raw=1 if High_Act>0.
- No arithmetic overflow: Count never exceeds Period_Act-1 ≤ 2^DIV_W-1.

Test Plan:
- Defaults: Reset then Enable=1, Mod_In=1 -> Out_Clock high 694 / low 695 cycles repeatedly; Period_Tick every 1389 cycles; Half_Tick at Count 0 and 694.
- Mid-period reload: Load Period=10, High=3 at Count=100 -> Load_Pending=1 until wrap at 1388; then 3 high / 7 low; Load_Pending=0.
- Mod gating: toggle Mod_In at Count=200 -> Out_Clock unchanged until next Count=0. Carrier_Raw and Half_Tick continue during space periods.
- Clamps: Load Period=1, High=5 -> period 2, constant high. Load High=0 -> constant low, no Half_Tick.
- Double load: two Loads (20/10 then 8/4) within one period -> only 8/4 takes effect at the wrap.
- Reset mid-operation: Reset at Count=500 with a load pending -> next cycle all outputs 0, defaults restored, Load_Pending=0.
